sobel_window_filter: RTL and testbench
======================================

// Module: sobel_window_filter
// PURPOSE
//  Consumer of the 3x3 RGB565 pixel window produced by the line buffer stage.
//  Converts the window to 8-bit luma, computes the Sobel gradient magnitude, and
//  emits one RGB565 pixel per clock with matched de/x/y, feeding the VGA output
//  mux and the motion-recognition hit logic.
//  Fixed 3-stage pipeline, one pixel per clock, no stalls.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line; x==0 / x==H_ACTIVE-1 are border columns
//  V_ACTIVE  480  active lines per frame; y==0 / y==V_ACTIVE-1 are border rows
// PORTS
//  clk          in   1   pixel clock; single clock domain
//  reset_n      in   1   asynchronous active-low reset
//  i_de         in   1   window valid (display-enable, aligned with window)
//  i_x          in   10  pixel column of window centre
//  i_y          in   10  pixel row of window centre
//  i_p00..i_p22 in   16  nine RGB565 window pixels; row r = 0 top..2 bottom, column c = 0..2
//  i_threshold  in   8   edge threshold for o_edge / binary mode
//  i_mode       in   2   0 pass centre, 1 gray, 2 magnitude, 3 binary edge
//  o_de         out  1   i_de delayed 3 clk
//  o_x          out  10  i_x delayed 3 clk
//  o_y          out  10  i_y delayed 3 clk
//  o_pixel      out  16  RGB565 result
//  o_edge       out  1   1 when mag >= i_threshold (all modes)
// BEHAVIOUR
//  Reset: all pipeline registers clear asynchronously.
//   o_de=0, o_x=0, o_y=0, o_pixel=16'h0000, o_edge=0.
//  Reset mid-frame: outputs drop to 0 immediately.
//   First valid output appears 3 clk after the first i_de=1 sampled after release.
//  Latency: exactly 3 clk from input sample to output, every cycle.
//   de, x, y, mode and centre pixel travel in lockstep.
//  Stage 1 (luma):
//   - Expand each pixel: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
//   - Y=(77*R8+150*G8+29*B8)>>8, 8-bit unsigned, no overflow (max 255).
//   - Register the 9 luma values; sample i_mode and i_threshold here.
//  Stage 2 (gradient), 11-bit signed:
//   - Gx=(Y02+2*Y12+Y22)-(Y00+2*Y10+Y20)
//   - Gy=(Y20+2*Y21+Y22)-(Y00+2*Y01+Y02)
//   - Border flag = (x==0 | x==H_ACTIVE-1 | y==0 | y==V_ACTIVE-1), carried forward.
//  Stage 3 (output):
//   - mag=|Gx|+|Gy| (12-bit), saturated to 255; forced 0 when border flag set.
//   - o_edge = o_de & (mag >= threshold); threshold 0 makes every active pixel an edge.
//   - o_pixel by mode (mode is sampled per pixel, so a change takes effect at that pixel):
//       mode 0: centre pixel unchanged
//       mode 1: {Yc[7:3],Yc[7:2],Yc[7:3]}
//       mode 2: {mag[7:3],mag[7:2],mag[7:3]}
//       mode 3: 16'hFFFF if o_edge else 16'h0000
//   - o_pixel=0 and o_edge=0 whenever the delayed de is 0.
//  Window inputs are ignored (treated don't-care) when i_de=0; no X may propagate to outputs.
// TESTING
//  1 Reset: hold reset_n=0, drive random inputs -> all outputs 0.
//    Release, i_de=1 at cycle 0 -> o_de=1 first at cycle 3.
//  2 Flat field: all pixels 16'hFFFF at x=100,y=100, mode 2 -> o_pixel=0, o_edge=0 for threshold 1.
//  3 Vertical step: column 0 = 16'h0000, columns 1,2 = 16'hFFFF, x=100,y=100, mode 3, thr 128
//    -> |Gx|=1020 saturates to 255, o_pixel=16'hFFFF, o_edge=1.
//  4 Border: same step at x=0, then x=639, y=0, y=479 -> mag 0, o_pixel=0 in mode 3.
//    Mode 0 still passes the centre pixel unchanged.
//  5 Mode/threshold switch mid-line: toggle mode 0->1 at pixel N
//    -> pixels < N output raw centre, >= N output gray; no glitch or extra latency.
//  6 Streaming 640x480 random frame vs reference model
//    -> bit-exact o_pixel/o_edge; o_x/o_y equal input delayed 3 clk.
//    Assert reset_n low at line 200 -> outputs clear that cycle; pipeline refills after 3 clk.

Source files
------------

// File: rtl/sobel_window_filter_if.sv
// rtl/sobel_window_filter_if.sv - window-in / pixel-out bundle for the Sobel filter stage
interface sobel_window_filter_if;
    logic        i_de;
    logic [9:0]  i_x;
    logic [9:0]  i_y;
    logic [15:0] i_p00, i_p01, i_p02;
    logic [15:0] i_p10, i_p11, i_p12;
    logic [15:0] i_p20, i_p21, i_p22;
    logic [7:0]  i_threshold;
    logic [1:0]  i_mode;

    logic        o_de;
    logic [9:0]  o_x;
    logic [9:0]  o_y;
    logic [15:0] o_pixel;
    logic        o_edge;

    modport master (
        output i_de, i_x, i_y,
        output i_p00, i_p01, i_p02, i_p10, i_p11, i_p12, i_p20, i_p21, i_p22,
        output i_threshold, i_mode,
        input  o_de, o_x, o_y, o_pixel, o_edge
    );

    modport slave (
        input  i_de, i_x, i_y,
        input  i_p00, i_p01, i_p02, i_p10, i_p11, i_p12, i_p20, i_p21, i_p22,
        input  i_threshold, i_mode,
        output o_de, o_x, o_y, o_pixel, o_edge
    );
endinterface

// File: rtl/sobel_window_filter.sv
// rtl/sobel_window_filter.sv - 3x3 RGB565 window to luma, Sobel magnitude and mode-selected pixel
module sobel_window_filter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sobel_window_filter_if.slave win
);

    function automatic logic [7:0] rgb565_luma(input logic [15:0] p);
        logic [7:0]  r8, g8, b8;
        logic [15:0] acc;
        r8  = {p[15:11], p[15:13]};
        g8  = {p[10:5],  p[10:9]};
        b8  = {p[4:0],   p[4:2]};
        acc = 16'd77 * r8 + 16'd150 * g8 + 16'd29 * b8;
        return 8'(acc >> 8);
    endfunction

    function automatic logic [15:0] gray565(input logic [7:0] v);
        return {v[7:3], v[7:2], v[7:3]};
    endfunction

    // index = row*3 + col, so [4] is the centre pixel
    logic [8:0][15:0] pix;

    // stage 1: luma
    logic             s1_de_d,    s1_de_q;
    logic [9:0]       s1_x_d,     s1_x_q;
    logic [9:0]       s1_y_d,     s1_y_q;
    logic [1:0]       s1_mode_d,  s1_mode_q;
    logic [7:0]       s1_thr_d,   s1_thr_q;
    logic [15:0]      s1_ctr_d,   s1_ctr_q;
    logic [8:0][7:0]  s1_luma_d,  s1_luma_q;

    // stage 2: gradient
    logic             s2_de_d,     s2_de_q;
    logic [9:0]       s2_x_d,      s2_x_q;
    logic [9:0]       s2_y_d,      s2_y_q;
    logic [1:0]       s2_mode_d,   s2_mode_q;
    logic [7:0]       s2_thr_d,    s2_thr_q;
    logic [15:0]      s2_ctr_d,    s2_ctr_q;
    logic [7:0]       s2_yc_d,     s2_yc_q;
    logic signed [10:0] s2_gx_d,   s2_gx_q;
    logic signed [10:0] s2_gy_d,   s2_gy_q;
    logic             s2_border_d, s2_border_q;
    logic [9:0]       gx_pos, gx_neg, gy_pos, gy_neg;

    // stage 3: output
    logic             o_de_d,    o_de_q;
    logic [9:0]       o_x_d,     o_x_q;
    logic [9:0]       o_y_d,     o_y_q;
    logic [15:0]      o_pixel_d, o_pixel_q;
    logic             o_edge_d,  o_edge_q;
    logic [10:0]      gx_abs, gy_abs;
    logic [11:0]      mag_sum;
    logic [7:0]       mag;

    always_comb begin
        pix = {win.i_p22, win.i_p21, win.i_p20,
               win.i_p12, win.i_p11, win.i_p10,
               win.i_p02, win.i_p01, win.i_p00};
    end

    // Window, mode and threshold are forced to zero when de is low so
    // undriven inputs during blanking never reach the outputs.
    always_comb begin
        s1_de_d   = win.i_de;
        s1_x_d    = win.i_x;
        s1_y_d    = win.i_y;
        s1_mode_d = win.i_de ? win.i_mode      : 2'd0;
        s1_thr_d  = win.i_de ? win.i_threshold : 8'd0;
        s1_ctr_d  = win.i_de ? pix[4]          : 16'd0;
        for (int k = 0; k < 9; k++) begin
            s1_luma_d[k] = win.i_de ? rgb565_luma(pix[k]) : 8'd0;
        end
    end

    always_comb begin
        gx_pos = {2'b00, s1_luma_q[2]} + {1'b0, s1_luma_q[5], 1'b0} + {2'b00, s1_luma_q[8]};
        gx_neg = {2'b00, s1_luma_q[0]} + {1'b0, s1_luma_q[3], 1'b0} + {2'b00, s1_luma_q[6]};
        gy_pos = {2'b00, s1_luma_q[6]} + {1'b0, s1_luma_q[7], 1'b0} + {2'b00, s1_luma_q[8]};
        gy_neg = {2'b00, s1_luma_q[0]} + {1'b0, s1_luma_q[1], 1'b0} + {2'b00, s1_luma_q[2]};

        s2_de_d     = s1_de_q;
        s2_x_d      = s1_x_q;
        s2_y_d      = s1_y_q;
        s2_mode_d   = s1_mode_q;
        s2_thr_d    = s1_thr_q;
        s2_ctr_d    = s1_ctr_q;
        s2_yc_d     = s1_luma_q[4];
        s2_gx_d     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        s2_gy_d     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
        s2_border_d = (s1_x_q == 10'd0) || (s1_x_q == 10'(H_ACTIVE - 1)) ||
                      (s1_y_q == 10'd0) || (s1_y_q == 10'(V_ACTIVE - 1));
    end

    always_comb begin
        gx_abs  = s2_gx_q[10] ? 11'(-s2_gx_q) : 11'(s2_gx_q);
        gy_abs  = s2_gy_q[10] ? 11'(-s2_gy_q) : 11'(s2_gy_q);
        mag_sum = {1'b0, gx_abs} + {1'b0, gy_abs};
        if (s2_border_q) begin
            mag = 8'd0;
        end else if (mag_sum > 12'd255) begin
            mag = 8'hFF;
        end else begin
            mag = mag_sum[7:0];
        end

        o_de_d   = s2_de_q;
        o_x_d    = s2_x_q;
        o_y_d    = s2_y_q;
        o_edge_d = s2_de_q && (mag >= s2_thr_q);
        case (s2_mode_q)
            2'd0:    o_pixel_d = s2_ctr_q;
            2'd1:    o_pixel_d = gray565(s2_yc_q);
            2'd2:    o_pixel_d = gray565(mag);
            default: o_pixel_d = o_edge_d ? 16'hFFFF : 16'h0000;
        endcase
        if (!s2_de_q) begin
            o_pixel_d = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_de_q     <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_mode_q   <= '0;
            s1_thr_q    <= '0;
            s1_ctr_q    <= '0;
            s1_luma_q   <= '0;
            s2_de_q     <= 1'b0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            s2_mode_q   <= '0;
            s2_thr_q    <= '0;
            s2_ctr_q    <= '0;
            s2_yc_q     <= '0;
            s2_gx_q     <= '0;
            s2_gy_q     <= '0;
            s2_border_q <= 1'b0;
            o_de_q      <= 1'b0;
            o_x_q       <= '0;
            o_y_q       <= '0;
            o_pixel_q   <= '0;
            o_edge_q    <= 1'b0;
        end else begin
            s1_de_q     <= s1_de_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_mode_q   <= s1_mode_d;
            s1_thr_q    <= s1_thr_d;
            s1_ctr_q    <= s1_ctr_d;
            s1_luma_q   <= s1_luma_d;
            s2_de_q     <= s2_de_d;
            s2_x_q      <= s2_x_d;
            s2_y_q      <= s2_y_d;
            s2_mode_q   <= s2_mode_d;
            s2_thr_q    <= s2_thr_d;
            s2_ctr_q    <= s2_ctr_d;
            s2_yc_q     <= s2_yc_d;
            s2_gx_q     <= s2_gx_d;
            s2_gy_q     <= s2_gy_d;
            s2_border_q <= s2_border_d;
            o_de_q      <= o_de_d;
            o_x_q       <= o_x_d;
            o_y_q       <= o_y_d;
            o_pixel_q   <= o_pixel_d;
            o_edge_q    <= o_edge_d;
        end
    end

    assign win.o_de    = o_de_q;
    assign win.o_x     = o_x_q;
    assign win.o_y     = o_y_q;
    assign win.o_pixel = o_pixel_q;
    assign win.o_edge  = o_edge_q;

endmodule

// File: tb/tb_sobel_window_filter.sv
// tb/tb_sobel_window_filter.sv - scoreboard bench for sobel_window_filter
module tb_sobel_window_filter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sobel_window_filter_if bus ();

    sobel_window_filter #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .win     (bus)
    );

    typedef struct {
        logic [15:0] pix;
        logic        edg;
        logic [9:0]  x;
        logic [9:0]  y;
        int          cyc;
        int          id;
    } exp_t;

    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          next_id = 0;
    logic [15:0] w [9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int id, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s id=%0d actual=%0h required=%0h", nm, id, act, req);
        end
    endtask

    function automatic logic [15:0] gray(input int v);
        return 16'(((v >> 3) << 11) | ((v >> 2) << 5) | (v >> 3));
    endfunction

    function automatic void model(input int x, input int y, input int mode, input int thr,
                                  output logic [15:0] px, output logic ed);
        int yv [9];
        int r, g, b, gx, gy, m;
        for (int k = 0; k < 9; k++) begin
            r = (int'(w[k]) >> 11) & 31;
            g = (int'(w[k]) >> 5) & 63;
            b = int'(w[k]) & 31;
            yv[k] = (77 * ((r << 3) | (r >> 2)) + 150 * ((g << 2) | (g >> 4)) +
                     29 * ((b << 3) | (b >> 2))) / 256;
        end
        gx = (yv[2] + 2 * yv[5] + yv[8]) - (yv[0] + 2 * yv[3] + yv[6]);
        gy = (yv[6] + 2 * yv[7] + yv[8]) - (yv[0] + 2 * yv[1] + yv[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        if (x == 0 || x == 639 || y == 0 || y == 479) m = 0;
        ed = (m >= thr);
        case (mode)
            0:       px = w[4];
            1:       px = gray(yv[4]);
            2:       px = gray(m);
            default: px = ed ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic drive(input logic de, input int x, input int y, input int mode, input int thr);
        bus.i_de = de;
        bus.i_x = 10'(x);  bus.i_y = 10'(y);
        bus.i_mode = 2'(mode);  bus.i_threshold = 8'(thr);
        bus.i_p00 = w[0]; bus.i_p01 = w[1]; bus.i_p02 = w[2];
        bus.i_p10 = w[3]; bus.i_p11 = w[4]; bus.i_p12 = w[5];
        bus.i_p20 = w[6]; bus.i_p21 = w[7]; bus.i_p22 = w[8];
    endtask

    task automatic send(input int x, input int y, input int mode, input int thr,
                        input logic [15:0] ep, input logic ee);
        exp_t e;
        @(negedge clk);
        drive(1'b1, x, y, mode, thr);
        e.pix = ep; e.edg = ee; e.x = 10'(x); e.y = 10'(y);
        e.cyc = cyc + 3; e.id = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 9; k++) w[k] = 16'($urandom);
            drive(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3), $urandom_range(0, 255));
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int k = 0; k < 9; k++) w[k] = v;
    endtask

    task automatic col_step(input int zero_col);
        for (int k = 0; k < 9; k++) w[k] = ((k % 3) == zero_col) ? 16'h0000 : 16'hFFFF;
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missing_output", sb[0].id, cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (bus.o_de) begin
                if (sb.size() == 0) begin
                    check("unexpected_de", -1, 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", e.id, cyc,       e.cyc);
                    check("pixel",   e.id, bus.o_pixel, e.pix);
                    check("edge",    e.id, bus.o_edge,  e.edg);
                    check("x",       e.id, bus.o_x,     e.x);
                    check("y",       e.id, bus.o_y,     e.y);
                end
            end else begin
                check("idle_pixel", -1, bus.o_pixel, 0);
                check("idle_edge",  -1, bus.o_edge,  0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ep;
        logic        ee;
        int          rx, ry;
        reset_n = 1'b0;
        fill(16'h0000);
        drive(1'b0, 0, 0, 0, 0);

        // reset: random activity on the inputs must not reach the outputs
        repeat (6) begin
            @(negedge clk);
            check("rst_de",    -1, bus.o_de,    0);
            check("rst_pixel", -1, bus.o_pixel, 0);
            check("rst_edge",  -1, bus.o_edge,  0);
            check("rst_x",     -1, bus.o_x,     0);
            check("rst_y",     -1, bus.o_y,     0);
            for (int k = 0; k < 9; k++) w[k] = 16'($urandom);
            drive(1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3), $urandom_range(0, 255));
        end
        @(negedge clk);
        bus.i_de = 1'b0;
        reset_n  = 1'b1;

        // flat white, magnitude mode
        fill(16'hFFFF);
        send(100, 100, 2, 1, 16'h0000, 1'b0);
        // vertical step, left column dark: Gx=1020 saturates
        col_step(0);
        send(100, 100, 3, 128, 16'hFFFF, 1'b1);
        send(100, 100, 2, 128, 16'hFFFF, 1'b1);
        // mirrored step exercises negative gradient
        col_step(2);
        send(100, 100, 3, 128, 16'hFFFF, 1'b1);
        // border positions suppress the magnitude
        col_step(0);
        send(0,   100, 3, 128, 16'h0000, 1'b0);
        send(639, 100, 3, 128, 16'h0000, 1'b0);
        send(100, 0,   3, 128, 16'h0000, 1'b0);
        send(100, 479, 3, 128, 16'h0000, 1'b0);
        send(0,   100, 0, 128, 16'hFFFF, 1'b0);
        send(638, 478, 3, 128, 16'hFFFF, 1'b1);
        send(1,   1,   3, 128, 16'hFFFF, 1'b1);
        // horizontal step: top row black, rest blue (Y=28) -> mag 112
        fill(16'h001F);
        for (int k = 0; k < 3; k++) w[k] = 16'h0000;
        send(200, 50, 2, 112, 16'h738E, 1'b1);
        send(200, 50, 2, 113, 16'h738E, 1'b0);
        send(200, 50, 3, 113, 16'h0000, 1'b0);
        send(200, 50, 0, 112, 16'h001F, 1'b1);
        // gray mode on primaries, threshold 0 flags every pixel
        fill(16'hF800);
        send(300, 60, 1, 0, 16'h4A69, 1'b1);
        fill(16'h07E0);
        send(301, 60, 1, 0, 16'h94B2, 1'b1);
        fill(16'h001F);
        send(302, 60, 1, 0, 16'h18E3, 1'b1);
        idle(3);
        // mode switch mid-line at pixel 4
        fill(16'hF800);
        for (int i = 0; i < 8; i++) begin
            send(400 + i, 70, (i < 4) ? 0 : 1, 0, (i < 4) ? 16'hF800 : 16'h4A69, 1'b1);
        end
        idle(2);

        // random windows against the reference model
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 9; k++) w[k] = 16'($urandom);
            rx = ($urandom_range(0, 7) == 0) ? 639 * $urandom_range(0, 1) : $urandom_range(0, 639);
            ry = ($urandom_range(0, 7) == 0) ? 479 * $urandom_range(0, 1) : $urandom_range(0, 479);
            begin
                int md, th;
                md = $urandom_range(0, 3);
                th = $urandom_range(0, 255);
                model(rx, ry, md, th, ep, ee);
                send(rx, ry, md, th, ep, ee);
            end
            if ($urandom_range(0, 9) == 0) idle(1);
        end

        // reset while the pipeline is full
        col_step(0);
        for (int i = 0; i < 4; i++) send(100 + i, 200, 0, 0, 16'hFFFF, 1'b1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_de",    -1, bus.o_de,    0);
        check("midrst_pixel", -1, bus.o_pixel, 0);
        check("midrst_x",     -1, bus.o_x,     0);
        sb.delete();
        bus.i_de = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        fill(16'hFFFF);
        send(10, 201, 0, 0, 16'hFFFF, 1'b1);
        col_step(0);
        send(11, 201, 3, 200, 16'hFFFF, 1'b1);
        idle(1);

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) check("drain_timeout", -1, sb.size(), 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
